// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and the memory (slave).
// The master holds memReq and all request fields until memAck; memRdata is
// valid in the same cycle as memAck for loads.
interface mem_access_unit_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memByteEn;
  logic        memAck;
  logic [31:0] memRdata;

  modport master (
    output memReq, memWe, memAddr, memWdata, memByteEn,
    input  memAck, memRdata
  );

  modport slave (
    input  memReq, memWe, memAddr, memWdata, memByteEn,
    output memAck, memRdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer feeding readDataExtend.
// Accepts one load/store, runs the req/ack handshake with data memory,
// builds byte enables and lane-replicated store data, and right-aligns the
// loaded word so the addressed byte/halfword sits at bit 0.
// Optional feature macro: MEM_TIMEOUT_EN -- aborts a BUSY transaction after
// TIMEOUT_CYCLES cycles without memAck (parameter exists only in that build).
module mem_access_unit
`ifdef MEM_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 256)
`endif
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req,
  input  logic                      i_we,
  input  logic [2:0]                i_funct3,
  input  logic [31:0]               i_addr,
  input  logic [31:0]               i_wdata,
  output logic                      o_stall,
  mem_access_unit_if.master         mem_bus,
  output logic [31:0]               o_readData,
  output logic [2:0]                o_readDataSrc,
  output logic                      o_readValid,
  output logic                      o_accessErr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Decoded request and FSM strobes
  logic        op_legal;
  logic [3:0]  req_byte_en;
  logic [31:0] lane_wdata;
  logic        accept;
  logic        reject;
  logic        ack_done;
  logic        timeout;

  // Registered outputs and captured op
  logic        memReq_q;
  logic        memWe_q;
  logic [31:0] memAddr_q;
  logic [31:0] memWdata_q;
  logic [3:0]  memByteEn_q;
  logic [31:0] readData_q;
  logic [2:0]  readDataSrc_q;
  logic        readValid_q;
  logic        accessErr_q;
  logic        we_q;
  logic [1:0]  off_q;

  // Legality: only b/h/w/bu/hu, with natural alignment for h and w
  always_comb begin
    op_legal = 1'b0;
    case (i_funct3)
      3'b000, 3'b100: op_legal = 1'b1;
      3'b001, 3'b101: op_legal = ~i_addr[0];
      3'b010:         op_legal = (i_addr[1:0] == 2'b00);
      default:        op_legal = 1'b0;
    endcase
  end

  // Byte enables; funct3[1:0] selects size, the unsigned variants share it
  always_comb begin
    req_byte_en = 4'b1111;
    case (i_funct3[1:0])
      2'b00:   req_byte_en = 4'b0001 << i_addr[1:0];
      2'b01:   req_byte_en = 4'b0011 << {i_addr[1], 1'b0};
      default: req_byte_en = 4'b1111;
    endcase
  end

  // Store data replicated across lanes so memory can pick by byte enable
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_wdata[8*gi +: 8] =
        (i_funct3[1:0] == 2'b00) ? i_wdata[7:0] :
        (i_funct3[1:0] == 2'b01) ? i_wdata[8*(gi%2) +: 8] :
                                   i_wdata[8*gi +: 8];
    end
  endgenerate

`ifdef MEM_TIMEOUT_EN
  // BUSY-cycle counter; hit marks the last BUSY cycle allowed without ack
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               timer_hit;

  assign timer_hit = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts at every accept and advances each ack-less BUSY cycle
  always_comb begin
    timer_d = timer_q;
    if (accept) begin
      timer_d = '0;
    end else if ((state_q == ST_BUSY) && !mem_bus.memAck) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Timeout counter register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, stall and transaction strobes
  always_comb begin
    state_d  = state_q;
    o_stall  = 1'b0;
    accept   = 1'b0;
    reject   = 1'b0;
    ack_done = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          if (op_legal) begin
            accept  = 1'b1;
            o_stall = 1'b1;
            state_d = ST_BUSY;
          end else begin
            // Illegal op retires immediately with an error pulse
            reject  = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        o_stall = 1'b1;
        if (mem_bus.memAck) begin
          // An ack coinciding with expiry still completes the op
          ack_done = 1'b1;
          state_d  = ST_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (timer_hit) begin
          timeout = 1'b1;
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        // Retiring op still sits on i_req, so it is not re-accepted here
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, memory-side registers and result pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      memReq_q      <= 1'b0;
      memWe_q       <= 1'b0;
      memAddr_q     <= '0;
      memWdata_q    <= '0;
      memByteEn_q   <= '0;
      readData_q    <= '0;
      readDataSrc_q <= 3'b010;
      readValid_q   <= 1'b0;
      accessErr_q   <= 1'b0;
      we_q          <= 1'b0;
      off_q         <= 2'b00;
    end else begin
      readValid_q <= 1'b0;
      accessErr_q <= 1'b0;
      if (accept) begin
        memReq_q      <= 1'b1;
        memWe_q       <= i_we;
        memAddr_q     <= {i_addr[31:2], 2'b00};
        memWdata_q    <= lane_wdata;
        memByteEn_q   <= req_byte_en;
        readDataSrc_q <= i_funct3;
        we_q          <= i_we;
        off_q         <= i_addr[1:0];
      end
      if (reject) begin
        accessErr_q <= 1'b1;
      end
      if (ack_done) begin
        memReq_q <= 1'b0;
        memWe_q  <= 1'b0;
        if (!we_q) begin
          readData_q  <= mem_bus.memRdata >> {off_q, 3'b000};
          readValid_q <= 1'b1;
        end
      end
      if (timeout) begin
        memReq_q    <= 1'b0;
        memWe_q     <= 1'b0;
        accessErr_q <= 1'b1;
      end
    end
  end

  assign mem_bus.memReq    = memReq_q;
  assign mem_bus.memWe     = memWe_q;
  assign mem_bus.memAddr   = memAddr_q;
  assign mem_bus.memWdata  = memWdata_q;
  assign mem_bus.memByteEn = memByteEn_q;

  assign o_readData    = readData_q;
  assign o_readDataSrc = readDataSrc_q;
  assign o_readValid   = readValid_q;
  assign o_accessErr   = accessErr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected memory,
// read and error events; a monitor pops and compares as the DUT shows them.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int EV_MEM  = 0;
  localparam int EV_READ = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        chk_wd;
    logic [31:0] rd;
    logic [2:0]  src;
  } exp_t;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_wait;
    logic        legal;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    int          exp_stall;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_stall;
  logic [31:0] o_readData;
  logic [2:0]  o_readDataSrc;
  logic        o_readValid;
  logic        o_accessErr;

  mem_access_unit_if mb();

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cycle = 0;
  exp_t exp_q[$];
  vec_t vecs[$];
  int   ack_wait = 0;
  logic [31:0] rdata_cfg = '0;
  int   busy_cnt = 0;

`ifdef MEM_TIMEOUT_EN
  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
  mem_access_unit dut (
`endif
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req         (i_req),
    .i_we          (i_we),
    .i_funct3      (i_funct3),
    .i_addr        (i_addr),
    .i_wdata       (i_wdata),
    .o_stall       (o_stall),
    .mem_bus       (mb),
    .o_readData    (o_readData),
    .o_readDataSrc (o_readDataSrc),
    .o_readValid   (o_readValid),
    .o_accessErr   (o_accessErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Memory responder: acks after ack_wait ack-less BUSY cycles
  always @(negedge clk) begin
    if (mb.memReq) begin
      if (busy_cnt == ack_wait) begin
        mb.memAck   = 1'b1;
        mb.memRdata = rdata_cfg;
      end else begin
        mb.memAck   = 1'b0;
        mb.memRdata = 32'h0;
      end
      busy_cnt++;
    end else begin
      mb.memAck   = 1'b0;
      mb.memRdata = 32'h0;
      busy_cnt    = 0;
    end
  end

  // Monitor: pops one expectation per observed DUT event
  task automatic pop_check(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cycle);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 32'(kind), 32'(e.kind));
    if (kind == EV_MEM) begin
      $display("cycle %0d MEM addr=0x%08h we=%0b be=%b wdata=0x%08h",
               cycle, mb.memAddr, mb.memWe, mb.memByteEn, mb.memWdata);
      check("mem_addr", mb.memAddr, e.addr);
      check("mem_we", 32'(mb.memWe), 32'(e.we));
      check("mem_byteen", 32'(mb.memByteEn), 32'(e.be));
      if (e.chk_wd) check("mem_wdata", mb.memWdata, e.wd);
    end else if (kind == EV_READ) begin
      $display("cycle %0d READ data=0x%08h src=%b", cycle, o_readData, o_readDataSrc);
      check("read_data", o_readData, e.rd);
      check("read_src", 32'(o_readDataSrc), 32'(e.src));
    end else begin
      $display("cycle %0d ERR pulse", cycle);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (mb.memReq && mb.memAck) pop_check(EV_MEM);
        if (o_readValid) pop_check(EV_READ);
        if (o_accessErr) pop_check(EV_ERR);
      end
    end
  end

  // Issue one op, push its expected events, count stall cycles
  task automatic run_op(input vec_t v);
    exp_t e;
    int   n;
    @(negedge clk);
    i_req = 1'b1; i_we = v.we; i_funct3 = v.f3; i_addr = v.addr; i_wdata = v.wdata;
    ack_wait = v.ack_wait; rdata_cfg = v.rdata;
    if (v.legal) begin
      e = '{EV_MEM, {v.addr[31:2], 2'b00}, v.we, v.exp_be, v.exp_wd, v.we, 32'h0, 3'b000};
      exp_q.push_back(e);
      if (!v.we) begin
        e = '{EV_READ, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, v.exp_rd, v.f3};
        exp_q.push_back(e);
      end
    end else begin
      e = '{EV_ERR, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 3'b000};
      exp_q.push_back(e);
    end
    n = 0;
    forever begin
      #1;
      if (!o_stall) break;
      n++;
      if (n > 60) begin
        $display("FAIL %s_stall_timeout: got >60 stall cycles expected %0d", v.name, v.exp_stall);
        break;
      end
      @(negedge clk);
    end
    check({v.name, "_stall_cycles"}, 32'(n), 32'(v.exp_stall));
    @(posedge clk);
    if (!v.legal) begin
      #1;
      check({v.name, "_no_memreq"}, 32'(mb.memReq), 32'h0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_memreq"},  32'(mb.memReq), 32'h0);
    check({tag, "_memwe"},   32'(mb.memWe), 32'h0);
    check({tag, "_memaddr"}, mb.memAddr, 32'h0);
    check({tag, "_memwdata"}, mb.memWdata, 32'h0);
    check({tag, "_byteen"},  32'(mb.memByteEn), 32'h0);
    check({tag, "_rdata"},   o_readData, 32'h0);
    check({tag, "_src"},     32'(o_readDataSrc), 32'h2);
    check({tag, "_rvalid"},  32'(o_readValid), 32'h0);
    check({tag, "_err"},     32'(o_accessErr), 32'h0);
    check({tag, "_stall"},   32'(o_stall), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b010; i_addr = '0; i_wdata = '0;
    mb.memAck = 1'b0; mb.memRdata = '0;

    //             name    we  f3      addr          wdata         rdata         ack legal be       exp_wd        exp_rd        stall
    vecs.push_back('{"lb103", 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80AA_BBCC, 2, 1'b1, 4'b1000, 32'h0,        32'h0000_0080, 4});
    vecs.push_back('{"sh202", 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        0, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0,        2});
    vecs.push_back('{"lw301", 1'b0, 3'b010, 32'h0000_0301, 32'h0,        32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0,        0});
    vecs.push_back('{"f3_011", 1'b0, 3'b011, 32'h0000_0000, 32'h0,       32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0,        0});
    vecs.push_back('{"lw400", 1'b0, 3'b010, 32'h0000_0400, 32'h0,        32'hDEAD_BEEF, 0, 1'b1, 4'b1111, 32'h0,        32'hDEAD_BEEF, 2});
    vecs.push_back('{"sw404", 1'b1, 3'b010, 32'h0000_0404, 32'h1122_3344, 32'h0,        0, 1'b1, 4'b1111, 32'h1122_3344, 32'h0,        2});
    vecs.push_back('{"lhu502", 1'b0, 3'b101, 32'h0000_0502, 32'h0,       32'hCAFE_1234, 1, 1'b1, 4'b1100, 32'h0,        32'h0000_CAFE, 3});
    vecs.push_back('{"sb601", 1'b1, 3'b000, 32'h0000_0601, 32'h0000_00A5, 32'h0,        0, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0,        2});
    vecs.push_back('{"lbu702", 1'b0, 3'b100, 32'h0000_0702, 32'h0,       32'h1122_3344, 0, 1'b1, 4'b0100, 32'h0,        32'h0000_1122, 2});
    vecs.push_back('{"sh801", 1'b1, 3'b001, 32'h0000_0801, 32'h5555_5555, 32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0,        0});
    vecs.push_back('{"f3_110", 1'b0, 3'b110, 32'h0000_0900, 32'h0,       32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0,        0});
    vecs.push_back('{"f3_111", 1'b1, 3'b111, 32'h0000_0A00, 32'h0,       32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0,        0});
    vecs.push_back('{"lh900", 1'b0, 3'b001, 32'h0000_0900, 32'h0,        32'h89AB_CDEF, 0, 1'b1, 4'b0011, 32'h0,        32'h89AB_CDEF, 2});

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Ops run back-to-back: each is presented the cycle after the previous retires
    foreach (vecs[i]) run_op(vecs[i]);
    @(negedge clk);
    i_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during BUSY: memReq must fall before the next clock edge
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0500;
    ack_wait = 1000; rdata_cfg = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("busy_memreq_high", 32'(mb.memReq), 32'h1);
    #2;
    i_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset_memreq", 32'(mb.memReq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("post_reset");

`ifdef MEM_TIMEOUT_EN
    // No ack: 4 BUSY cycles then abort into DONE with only an error pulse
    v = '{"lw_timeout", 1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h0, 1000, 1'b1, 4'b1111, 32'h0, 32'h0, 5};
    begin
      exp_t e;
      int   n;
      @(negedge clk);
      i_req = 1'b1; i_we = v.we; i_funct3 = v.f3; i_addr = v.addr;
      ack_wait = v.ack_wait;
      e = '{EV_ERR, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 3'b000};
      exp_q.push_back(e);
      n = 0;
      forever begin
        #1;
        if (!o_stall) break;
        n++;
        if (n > 60) begin
          $display("FAIL timeout_stall_bound: got >60 stall cycles expected 5");
          break;
        end
        @(negedge clk);
      end
      check("timeout_stall_cycles", 32'(n), 32'(v.exp_stall));
      check("timeout_done_memreq", 32'(mb.memReq), 32'h0);
      @(negedge clk);
      i_req = 1'b0;
    end
`else
    v = vecs[0];
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
